// File: rtl/led_frame_scheduler.sv
// Frame sequencer for the 32-square WS2812 board: snapshots piece masks, kicks the
// serializer, watches it with a watchdog and enforces the strip latch gap.
module led_frame_scheduler #(
  parameter int SYS_FREQ_MHZ   = 100,
  parameter int LATCH_US       = 80,
  parameter int REFRESH_CYCLES = 1666667,
  parameter int SEND_TIMEOUT   = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_req,
  input  logic [31:0] player_pieces_in,
  input  logic [31:0] cpu_pieces_in,
  input  logic [31:0] king_pieces_in,
  input  logic        ser_ready,
  input  logic        ser_done,
  output logic [31:0] player_pieces_out,
  output logic [31:0] cpu_pieces_out,
  output logic [31:0] king_pieces_out,
  output logic        ser_start,
  output logic        busy,
  output logic        conflict,
  output logic        timeout_err,
  output logic [15:0] frame_count
);
  localparam int LATCH_CYCLES = SYS_FREQ_MHZ * LATCH_US;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam int TW = (SEND_TIMEOUT > 1) ? $clog2(SEND_TIMEOUT) : 1;
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_CYCLES - 1);
  localparam logic [LW-1:0] LAT_MAX = LW'(LATCH_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(SEND_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, SEND, LATCH} state_t;

  state_t        state, state_nxt;
  logic          pending;
  logic [RW-1:0] refresh_cnt;
  logic [LW-1:0] latch_cnt;
  logic [TW-1:0] timeout_cnt;
  logic          refresh_due, latch_last, send_tmo;

  assign refresh_due = (refresh_cnt == REF_MAX);
  assign latch_last  = (latch_cnt == LAT_MAX);
  assign send_tmo    = (timeout_cnt == TMO_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pending || frame_req || refresh_due) state_nxt = LOAD;
      LOAD:    state_nxt = START;
      START:   if (ser_ready) state_nxt = SEND;
      SEND:    if (ser_done || send_tmo) state_nxt = LATCH;
      LATCH:   if (latch_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ser_start = (state == START) && ser_ready;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending           <= 1'b1;  // blank the strip right after reset
      refresh_cnt       <= '0;
      latch_cnt         <= '0;
      timeout_cnt       <= '0;
      player_pieces_out <= '0;
      cpu_pieces_out    <= '0;
      king_pieces_out   <= '0;
      conflict          <= 1'b0;
      timeout_err       <= 1'b0;
      frame_count       <= '0;
    end else begin
      // A request landing in LOAD must still win over the clear.
      if (frame_req && state != IDLE) pending <= 1'b1;
      else if (state == LOAD)         pending <= 1'b0;

      // Saturating so a period that elapses while busy fires on return to IDLE.
      if (state == LOAD)     refresh_cnt <= '0;
      else if (!refresh_due) refresh_cnt <= refresh_cnt + RW'(1);

      if (state == LOAD) begin
        player_pieces_out <= player_pieces_in;
        cpu_pieces_out    <= cpu_pieces_in & ~player_pieces_in;
        king_pieces_out   <= king_pieces_in;
        conflict          <= conflict | (|(player_pieces_in & cpu_pieces_in));
      end

      timeout_cnt <= (state == SEND) ? timeout_cnt + TW'(1) : '0;
      if (state == SEND && send_tmo && !ser_done) timeout_err <= 1'b1;

      if (state == LATCH) latch_cnt <= latch_last ? '0 : latch_cnt + LW'(1);
      else                latch_cnt <= '0;

      if (state == LATCH && latch_last) frame_count <= frame_count + 16'd1;
    end
  end
endmodule
